// File: rtl/ntt8_seq_controller_if.sv
// Handshake, twiddle and status bundle for ntt8_seq_controller.
// The master side is the system or bench; the slave side is the controller.
interface ntt8_seq_controller_if #(
    parameter int DW = 8
);
    logic          start;
    logic [DW-1:0] mod;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    tw_idx;
    logic [DW-1:0] tw_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, mod, in_valid, in_data, tw_data, out_ready,
        input  in_ready, tw_idx, out_valid, out_data, busy, done, err
    );

    modport slave (
        input  start, mod, in_valid, in_data, tw_data, out_ready,
        output in_ready, tw_idx, out_valid, out_data, busy, done, err
    );
endinterface

// File: rtl/ntt8_seq_controller.sv
// Iterative 8-point NTT: serial load, 12 in-place butterflies on one shared unit, serial drain.
// Optional macro NTT8_BITREV_OUT_EN drains memory in bit-reversed address order.
module ntt8_seq_controller #(
    parameter int DW   = 8,
    parameter int N    = 8,
    parameter int LOGN = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    ntt8_seq_controller_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam int KW = $clog2(N / 2);
    localparam int SW = $clog2(LOGN);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [KW-1:0] LAST_BF  = KW'(N / 2 - 1);
    localparam logic [SW-1:0] LAST_STG = SW'(LOGN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] q_r;
    logic [DW-1:0] mem [N];
    logic [AW-1:0] cnt, ocnt;
    logic [KW-1:0] bk;
    logic [SW-1:0] stg;
    logic [DW-1:0] out_data_q;
    logic          done_q, err_q;

    logic start_ok, start_bad, load_hs, bf_en, out_hs;

    // Butterfly addressing: g*half = k - o, so i = 2*(k - o) + o.
    logic [AW-1:0]   half, bi, bj;
    logic [KW-1:0]   o, t;
    logic [DW-1:0]   a, b, p, bf_hi, bf_lo, in_red;
    logic [2*DW-1:0] prod;
    logic [DW:0]     sum;

    function automatic logic [AW-1:0] oidx(input logic [AW-1:0] c);
        logic [AW-1:0] r;
        r = '0;
`ifdef NTT8_BITREV_OUT_EN
        for (int unsigned n = 0; n < AW; n++) r[n] = c[AW-1-n];
`else
        r = c;
`endif
        return r;
    endfunction

    always_comb begin
        half   = AW'(N / 2) >> stg;
        o      = KW'(AW'(bk) & (half - AW'(1)));
        t      = o << stg;
        bi     = AW'({bk - o, 1'b0}) + AW'(o);
        bj     = bi + half;
        a      = mem[bi];
        b      = mem[bj];
        prod   = {{DW{1'b0}}, b} * {{DW{1'b0}}, bus.tw_data};
        p      = DW'(prod % {{DW{1'b0}}, q_r});
        sum    = {1'b0, a} + {1'b0, p};
        bf_hi  = (sum >= {1'b0, q_r}) ? DW'(sum - {1'b0, q_r}) : DW'(sum);
        bf_lo  = (a >= p) ? (a - p) : DW'({1'b0, a} + {1'b0, q_r} - {1'b0, p});
        in_red = bus.in_data % q_r;
    end

    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        load_hs   = 1'b0;
        bf_en     = 1'b0;
        out_hs    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.mod >= DW'(2)) begin
                        start_ok = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    load_hs = 1'b1;
                    if (cnt == LAST_IDX) state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                bf_en = 1'b1;
                if (stg == LAST_STG && bk == LAST_BF) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    out_hs = 1'b1;
                    if (ocnt == LAST_IDX) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            q_r        <= '0;
            cnt        <= '0;
            ocnt       <= '0;
            bk         <= '0;
            stg        <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int unsigned n = 0; n < N; n++) mem[n] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= out_hs && (ocnt == LAST_IDX);
            err_q   <= start_bad;
            if (start_ok) q_r <= bus.mod;
            if (load_hs) begin
                mem[cnt] <= in_red;
                cnt      <= cnt + AW'(1);
            end
            if (bf_en) begin
                mem[bi] <= bf_hi;
                mem[bj] <= bf_lo;
                bk      <= bk + KW'(1);
                if (bk == LAST_BF) stg <= (stg == LAST_STG) ? '0 : stg + SW'(1);
            end
            // The final butterfly writes addresses 6/7, never the first drained word.
            if (state_q == COMPUTE && state_d == DRAIN) out_data_q <= mem[oidx('0)];
            if (out_hs) begin
                ocnt       <= ocnt + AW'(1);
                out_data_q <= (ocnt == LAST_IDX) ? '0 : mem[oidx(ocnt + AW'(1))];
            end
        end
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.busy      = (state_q != IDLE);
    assign bus.tw_idx    = (state_q == COMPUTE) ? t : '0;
    assign bus.out_data  = out_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
